// File: rtl/uart_tx_fifo_reader_if.sv
// rtl/uart_tx_fifo_reader_if.sv - FIFO read-side and serial line signals of the UART transmitter
interface uart_tx_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             par_en;
  logic             par_typ;
  logic             fifo_rd_inc;
  logic             tx_out;
  logic             busy;

  // FIFO / configuration side
  modport master (
    output fifo_empty, fifo_data, par_en, par_typ,
    input  fifo_rd_inc, tx_out, busy
  );

  // Transmitter side
  modport slave (
    input  fifo_empty, fifo_data, par_en, par_typ,
    output fifo_rd_inc, tx_out, busy
  );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - pops FIFO words and serialises them as UART frames, one bit per clk
module uart_tx_fifo_reader #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_fifo_reader_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             par_en_q, par_en_nxt;
  logic             par_bit_q, par_bit_nxt;
  logic             tx_q, tx_nxt;
  logic             busy_q, busy_nxt;
  logic             rd_q, rd_nxt;
  logic             capture;

  // State register; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, datapath and next registered output values
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    cnt_nxt     = cnt_q;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit_q;
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b0;
    rd_nxt      = 1'b0;
    capture     = ((state == IDLE) || (state == STOP)) && !bus.fifo_empty;

    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      START: begin
        state_nxt = DATA;
        tx_nxt    = shift_q[0];
        shift_nxt = shift_q >> 1;
        cnt_nxt   = '0;
        busy_nxt  = 1'b1;
      end
      DATA: begin
        busy_nxt = 1'b1;
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit_q;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          tx_nxt    = shift_q[0];
          shift_nxt = shift_q >> 1;
          cnt_nxt   = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // FIFO data and configuration are only looked at when a word is present
    if (capture) begin
      state_nxt   = START;
      shift_nxt   = bus.fifo_data;
      par_en_nxt  = bus.par_en;
      par_bit_nxt = bus.par_typ ? ~^bus.fifo_data : ^bus.fifo_data;
      tx_nxt      = 1'b0;
      busy_nxt    = 1'b1;
      rd_nxt      = 1'b1;
    end
  end

  // Datapath and output registers; outputs idle high / inactive in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      shift_q   <= shift_nxt;
      cnt_q     <= cnt_nxt;
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
      tx_q      <= tx_nxt;
      busy_q    <= busy_nxt;
      rd_q      <= rd_nxt;
    end
  end

  assign bus.tx_out      = tx_q;
  assign bus.busy        = busy_q;
  assign bus.fifo_rd_inc = rd_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - directed self-checking bench for uart_tx_fifo_reader
module tb_uart_tx_fifo_reader;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_reader_if #(.WIDTH(WIDTH)) bus ();

  uart_tx_fifo_reader #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] fifo_q[$];
  logic       tx_log[$];
  logic       busy_log[$];
  logic       rd_log[$];
  logic [7:0] rx_q[$];

  logic [7:0] vec[16] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h7E, 8'hC3,
                          8'h3C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fifo_q.size() == 0) begin
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = WIDTH'($urandom);
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_data  = fifo_q[0];
    end
  endtask

  task automatic step();
    logic [7:0] dummy;
    @(negedge clk);
    tx_log.push_back(bus.tx_out);
    busy_log.push_back(bus.busy);
    rd_log.push_back(bus.fifo_rd_inc);
    if (bus.fifo_rd_inc && fifo_q.size() > 0) dummy = fifo_q.pop_front();
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_pop(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (rd_log[rd_log.size()-1] == 1'b1) break;
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    busy_log.delete();
    rd_log.delete();
  endtask

  function automatic int find_pop(input int from);
    for (int i = from; i < rd_log.size(); i++)
      if (rd_log[i] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_pops();
    int n = 0;
    foreach (rd_log[i]) if (rd_log[i] == 1'b1) n++;
    return n;
  endfunction

  task automatic check_frame(input string tag, input int s, input logic [7:0] d,
                             input logic pe, input logic exp_par);
    int len;
    logic [31:0] exp_tx, act_tx, exp_busy, act_busy;
    len = pe ? 11 : 10;
    exp_tx = '0;
    for (int i = 0; i < 8; i++) exp_tx[i+1] = d[i];
    if (pe) exp_tx[9] = exp_par;
    exp_tx[len-1] = 1'b1;
    exp_busy = (32'd1 << len) - 32'd1;
    act_tx = '0;
    act_busy = '0;
    if (s < 0 || s + len > tx_log.size()) begin
      check({tag, "_found"}, 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < len; i++) begin
      act_tx[i]   = tx_log[s+i];
      act_busy[i] = busy_log[s+i];
    end
    check({tag, "_tx"}, act_tx, exp_tx);
    check({tag, "_busy"}, act_busy, exp_busy);
  endtask

  task automatic check_idle_after(input string tag, input int idx);
    if (idx < 0 || idx >= tx_log.size()) begin
      check({tag, "_idle_found"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_idle_tx"}, 32'(tx_log[idx]), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy_log[idx]), 32'd0);
  endtask

  task automatic single_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input logic exp_par);
    int s;
    clear_logs();
    bus.par_en = pe;
    bus.par_typ = pt;
    fifo_q.push_back(d);
    drive_fifo();
    run(16);
    s = find_pop(0);
    check({tag, "_pops"}, 32'(count_pops()), 32'd1);
    check_frame(tag, s, d, pe, exp_par);
    check_idle_after(tag, (s < 0) ? -1 : s + (pe ? 11 : 10));
  endtask

  initial begin
    int s, p0, p1, ones, busys, idx, nrx, stop_err;
    logic [7:0] b;

    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    drive_fifo();

    // Reset state
    run(3);
    check("rst_tx", 32'(bus.tx_out), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd", 32'(bus.fifo_rd_inc), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Single frames, with and without parity
    single_frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    single_frame("t2_03_even", 8'h03, 1'b1, 1'b0, 1'b0);
    single_frame("t2_03_odd", 8'h03, 1'b1, 1'b1, 1'b1);

    // Parity configuration changed mid-frame must not affect the frame
    clear_logs();
    bus.par_en = 1'b1;
    bus.par_typ = 1'b0;
    fifo_q.push_back(8'h07);
    drive_fifo();
    run_until_pop(5);
    bus.par_en = 1'b0;
    bus.par_typ = 1'b1;
    run(14);
    s = find_pop(0);
    check_frame("t2_07_even", s, 8'h07, 1'b1, 1'b1);
    check_idle_after("t2_07", (s < 0) ? -1 : s + 11);
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;

    // Back-to-back words
    clear_logs();
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h0F);
    drive_fifo();
    run(26);
    p0 = find_pop(0);
    p1 = (p0 < 0) ? -1 : find_pop(p0 + 1);
    check("t3_pops", 32'(count_pops()), 32'd2);
    check("t3_spacing", 32'(p1 - p0), 32'd10);
    check_frame("t3_55", p0, 8'h55, 1'b0, 1'b0);
    check_frame("t3_0f", p1, 8'h0F, 1'b0, 1'b0);
    check_idle_after("t3", (p1 < 0) ? -1 : p1 + 10);

    // Empty FIFO with garbage data
    clear_logs();
    run(50);
    ones = 0;
    busys = 0;
    foreach (tx_log[i]) if (tx_log[i] == 1'b1) ones++;
    foreach (busy_log[i]) if (busy_log[i] == 1'b1) busys++;
    check("t4_pops", 32'(count_pops()), 32'd0);
    check("t4_tx_high", 32'(ones), 32'd50);
    check("t4_busy", 32'(busys), 32'd0);

    // Reset during data bit 3
    clear_logs();
    fifo_q.push_back(8'hFF);
    drive_fifo();
    run_until_pop(5);
    run(4);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(bus.tx_out), 32'd1);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_rd", 32'(bus.fifo_rd_inc), 32'd0);
    fifo_q.push_back(8'h3C);
    drive_fifo();
    step();
    rst_n = 1'b1;
    clear_logs();
    run(14);
    s = find_pop(0);
    check("t5_restart_idx", 32'(s), 32'd0);
    check_frame("t5_3c", s, 8'h3C, 1'b0, 1'b0);

    // Sixteen words through a reference receiver
    clear_logs();
    foreach (vec[i]) fifo_q.push_back(vec[i]);
    drive_fifo();
    run(16 * 10 + 8);
    idx = 0;
    nrx = 0;
    stop_err = 0;
    rx_q.delete();
    while (idx + 9 < tx_log.size() && nrx < 16) begin
      if (tx_log[idx] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = tx_log[idx+1+k];
        if (tx_log[idx+9] != 1'b1) stop_err++;
        rx_q.push_back(b);
        nrx++;
        idx += 10;
      end else begin
        idx++;
      end
    end
    check("t6_pops", 32'(count_pops()), 32'd16);
    check("t6_rx_count", 32'(rx_q.size()), 32'd16);
    check("t6_stop_errors", 32'(stop_err), 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (k < rx_q.size()) check($sformatf("t6_byte%0d", k), 32'(rx_q[k]), 32'(vec[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
